// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - 256-bit command/response types shared by the I/O bridge blocks
package wishbone_pkg;

  localparam logic [1:0] OK  = 2'd0;
  localparam logic [1:0] ERR = 2'd1;
  localparam logic [1:0] IRQ = 2'd2;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [7:0]   tid;
    logic [255:0] dat;
  } wb_cmd_request256_t;

  typedef struct packed {
    logic         ack;
    logic [1:0]   err;
    logic [7:0]   tid;
    logic [255:0] dat;
  } wb_cmd_response256_t;

endpackage

// File: rtl/wb_io_arbiter256.sv
// rtl/wb_io_arbiter256.sv - round-robin arbiter sharing one 256-bit bridge port among NREQ requesters
module wb_io_arbiter256
  import wishbone_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 255,
  parameter int IRQ_DEST = 0
) (
  input  logic                rst_i,
  input  logic                clk_i,
  input  wb_cmd_request256_t  s_req [NREQ],
  output wb_cmd_response256_t s_resp [NREQ],
  output wb_cmd_request256_t  m_req,
  input  wb_cmd_response256_t m_resp,
  output logic [NREQ-1:0]     gnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);
  localparam logic [IW-1:0] IRQ_IDX = IW'(IRQ_DEST);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, TMO, DRAIN} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx;
  logic [IW-1:0]   sel_idx;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
  logic [NREQ-1:0] gnt_nx;
  logic            any_req;
  int              scan_idx;

  // Scan from the highest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    any_req  = 1'b0;
    sel_idx  = '0;
    scan_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (s_req[IW'(scan_idx)].cyc) begin
        any_req = 1'b1;
        sel_idx = IW'(scan_idx);
      end
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      gnt    <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_ptr_nx;
      cnt    <= cnt_nx;
      gnt    <= gnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    cnt_nx    = cnt;
    gnt_nx    = gnt;
    m_req     = '0;
    m_req.adr = 32'hFFFF_FFFF;
    for (int i = 0; i < NREQ; i++) s_resp[i] = '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx  = BUSY;
          owner_nx  = sel_idx;
          gnt_nx    = NREQ'(1) << sel_idx;
          rr_ptr_nx = (sel_idx == LAST_IDX) ? '0 : sel_idx + IW'(1);
          cnt_nx    = '0;
        end
        // Unsolicited interrupts go to a fixed requester; gated so reset never leaks one.
        if (!rst_i && m_resp.ack && m_resp.err == IRQ) s_resp[IRQ_IDX] = m_resp;
      end
      BUSY: begin
        m_req         = s_req[owner];
        s_resp[owner] = m_resp;
        if (!s_req[owner].cyc) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          cnt_nx   = '0;
        end else if (m_resp.ack) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= TMO_VAL) state_nx = TMO;
        end
      end
      TMO: begin
        s_resp[owner].ack = 1'b1;
        s_resp[owner].err = ERR;
        s_resp[owner].tid = s_req[owner].tid;
        state_nx          = DRAIN;
      end
      DRAIN: begin
        if (!s_req[owner].cyc) begin
          state_nx = IDLE;
          gnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_io_arbiter256.sv
// tb/tb_wb_io_arbiter256.sv - self-checking bench for wb_io_arbiter256 (NREQ=4, TIMEOUT=8, IRQ_DEST=2)
module tb_wb_io_arbiter256;
  import wishbone_pkg::*;

  localparam int NREQ = 4;
  localparam int DEST = 2;
  localparam int NV   = 10;

  logic                clk_i = 1'b0;
  logic                rst_i;
  wb_cmd_request256_t  s_req [NREQ];
  wb_cmd_response256_t s_resp [NREQ];
  wb_cmd_request256_t  m_req;
  wb_cmd_response256_t m_resp;
  logic [NREQ-1:0]     gnt;

  wb_io_arbiter256 #(.NREQ(NREQ), .TIMEOUT(8), .IRQ_DEST(DEST)) dut (
    .rst_i (rst_i),
    .clk_i (clk_i),
    .s_req (s_req),
    .s_resp(s_resp),
    .m_req (m_req),
    .m_resp(m_resp),
    .gnt   (gnt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           idx;
    logic [255:0] dat;
    logic [1:0]   err;
    logic [7:0]   tid;
  } resp_exp_t;

  typedef struct {
    logic       rst_first;
    logic [3:0] mask;
    int         owner;
    int         gap;
    int         nack;
    int         post;
    logic [7:0] byte_v;
  } vec_t;

  resp_exp_t resp_q[$];
  int        gnt_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  logic [NREQ-1:0] prev_gnt = '0;
  resp_exp_t mon_e;
  int        mon_g;
  vec_t      vt [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_d(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input int idx, input logic [255:0] dat, input logic [1:0] err,
                             input logic [7:0] tid);
    resp_exp_t e;
    e.idx = idx;
    e.dat = dat;
    e.err = err;
    e.tid = tid;
    resp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Response scoreboard: every ack seen on any s_resp must match the next expected one.
  always @(negedge clk_i) begin
    for (int i = 0; i < NREQ; i++) begin
      if (s_resp[i].ack === 1'b1) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: requester %0d got ack err=%0d, none required", i, s_resp[i].err);
        end else begin
          mon_e = resp_q.pop_front();
          check("resp_idx", 64'(i), 64'(mon_e.idx));
          check_d("resp_dat", s_resp[i].dat, mon_e.dat);
          check("resp_err", 64'(s_resp[i].err), 64'(mon_e.err));
          check("resp_tid", 64'(s_resp[i].tid), 64'(mon_e.tid));
        end
      end
    end
    if (gnt !== '0 && gnt !== prev_gnt) begin
      if (gnt_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grant: got %b, none required", gnt);
      end else begin
        mon_g = gnt_q.pop_front();
        check("grant_order", 64'(gnt), 64'(1) << mon_g);
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int own;
    int total;
    logic [255:0] d;

    vt[0] = '{1'b1, 4'b0100, 2, 2, 1, 0, 8'hA5};
    vt[1] = '{1'b1, 4'b1111, 0, 0, 1, 0, 8'h10};
    vt[2] = '{1'b0, 4'b1111, 1, 0, 1, 0, 8'h11};
    vt[3] = '{1'b0, 4'b1111, 2, 0, 1, 0, 8'h12};
    vt[4] = '{1'b0, 4'b1111, 3, 0, 1, 0, 8'h13};
    vt[5] = '{1'b0, 4'b1111, 0, 0, 1, 0, 8'h14};
    vt[6] = '{1'b0, 4'b0001, 0, 6, 4, 6, 8'h5A};
    vt[7] = '{1'b0, 4'b0100, 2, 1, 1, 0, 8'h77};
    vt[8] = '{1'b0, 4'b1001, 3, 0, 2, 1, 8'h33};
    vt[9] = '{1'b0, 4'b0011, 0, 0, 1, 0, 8'hC3};

    rst_i  = 1'b1;
    m_resp = '0;
    for (int i = 0; i < NREQ; i++) s_req[i] = '0;
    #2;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_m_adr", 64'(m_req.adr), 64'(32'hFFFF_FFFF));
    check("rst_m_cyc", 64'(m_req.cyc), 64'(0));
    for (int i = 0; i < NREQ; i++) check("rst_s_ack", 64'(s_resp[i].ack), 64'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int v = 0; v < NV; v++) begin
      if (vt[v].rst_first) begin
        rst_i = 1'b1;
        for (int i = 0; i < NREQ; i++) s_req[i] = '0;
        step();
        rst_i = 1'b0;
      end
      own = vt[v].owner;
      for (int i = 0; i < NREQ; i++) begin
        s_req[i].cyc = vt[v].mask[i];
        s_req[i].stb = vt[v].mask[i];
        s_req[i].we  = (i % 2) == 1;
        s_req[i].adr = 32'h1000_0000 + 32'(v * 256 + i * 16);
        s_req[i].tid = 8'(v * 4 + i);
        s_req[i].dat = {32{8'(i + 1)}};
      end
      gnt_q.push_back(own);
      @(negedge clk_i);
      check("grant_latency", 64'(gnt), 64'(0));
      step();
      total = vt[v].gap + vt[v].nack + vt[v].post;
      for (int c = 1; c <= total; c++) begin
        if (c > vt[v].gap && c <= vt[v].gap + vt[v].nack) begin
          d = {32{vt[v].byte_v}} ^ 256'(c - vt[v].gap - 1);
          m_resp.ack = 1'b1;
          m_resp.err = OK;
          m_resp.tid = s_req[own].tid;
          m_resp.dat = d;
          expect_resp(own, d, OK, s_req[own].tid);
        end else begin
          m_resp = '0;
        end
        @(negedge clk_i);
        if (c == 1) begin
          check("m_req_adr", 64'(m_req.adr), 64'(s_req[own].adr));
          check("m_req_cyc", 64'(m_req.cyc), 64'(1));
          check_d("m_req_dat", m_req.dat, s_req[own].dat);
        end
        check("grant_hold", 64'(gnt), 64'(1) << own);
        step();
      end
      m_resp = '0;
      s_req[own].cyc = 1'b0;
      s_req[own].stb = 1'b0;
      @(negedge clk_i);
      check("drop_hold", 64'(gnt), 64'(1) << own);
      step();
      check("idle_gnt", 64'(gnt), 64'(0));
      check("idle_m_adr", 64'(m_req.adr), 64'(32'hFFFF_FFFF));
    end

    // Timeout on requester 1 with TIMEOUT=8.
    rst_i = 1'b1;
    for (int i = 0; i < NREQ; i++) s_req[i] = '0;
    step();
    rst_i = 1'b0;
    s_req[1].cyc = 1'b1;
    s_req[1].stb = 1'b1;
    s_req[1].tid = 8'h3C;
    s_req[1].adr = 32'h2000_0040;
    gnt_q.push_back(1);
    @(negedge clk_i);
    check("tmo_latency", 64'(gnt), 64'(0));
    step();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      check("tmo_early_ack", 64'(s_resp[1].ack), 64'(0));
      check("tmo_busy_cyc", 64'(m_req.cyc), 64'(1));
      step();
    end
    expect_resp(1, '0, ERR, 8'h3C);
    @(negedge clk_i);
    check("tmo_ack", 64'(s_resp[1].ack), 64'(1));
    check("tmo_err", 64'(s_resp[1].err), 64'(ERR));
    check("tmo_m_cyc", 64'(m_req.cyc), 64'(0));
    step();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check("drain_gnt", 64'(gnt), 64'(4'b0010));
      check("drain_m_cyc", 64'(m_req.cyc), 64'(0));
      check("drain_ack", 64'(s_resp[1].ack), 64'(0));
      step();
    end
    s_req[1].cyc = 1'b0;
    @(negedge clk_i);
    check("drain_drop_hold", 64'(gnt), 64'(4'b0010));
    step();
    check("drain_idle", 64'(gnt), 64'(0));

    // Unsolicited IRQ in IDLE.
    d = {32{8'h3E}};
    m_resp.ack = 1'b1;
    m_resp.err = IRQ;
    m_resp.tid = 8'h99;
    m_resp.dat = d;
    expect_resp(DEST, d, IRQ, 8'h99);
    @(negedge clk_i);
    for (int i = 0; i < NREQ; i++)
      if (i != DEST) check("irq_other_ack", 64'(s_resp[i].ack), 64'(0));
    check("irq_gnt", 64'(gnt), 64'(0));
    step();
    m_resp = '0;
    @(negedge clk_i);
    check("irq_one_cycle", 64'(s_resp[DEST].ack), 64'(0));
    step();

    // IRQ and grant request in the same IDLE cycle, then IRQ while BUSY goes to the owner.
    s_req[3].cyc = 1'b1;
    s_req[3].tid = 8'h44;
    m_resp.ack   = 1'b1;
    m_resp.err   = IRQ;
    m_resp.tid   = 8'h55;
    m_resp.dat   = {32{8'h6B}};
    expect_resp(DEST, {32{8'h6B}}, IRQ, 8'h55);
    gnt_q.push_back(3);
    @(negedge clk_i);
    check("irq_grant_latency", 64'(gnt), 64'(0));
    step();
    m_resp = '0;
    @(negedge clk_i);
    check("irq_grant", 64'(gnt), 64'(4'b1000));
    step();
    m_resp.ack = 1'b1;
    m_resp.err = IRQ;
    m_resp.tid = 8'h66;
    m_resp.dat = {32{8'h81}};
    expect_resp(3, {32{8'h81}}, IRQ, 8'h66);
    @(negedge clk_i);
    check("irq_busy_dest_ack", 64'(s_resp[DEST].ack), 64'(0));
    step();
    m_resp = '0;
    s_req[3].cyc = 1'b0;
    step();
    check("irq_busy_idle", 64'(gnt), 64'(0));

    // Asynchronous reset pulse in the middle of a BUSY cycle.
    s_req[0].cyc = 1'b1;
    s_req[0].tid = 8'h21;
    gnt_q.push_back(0);
    step();
    @(negedge clk_i);
    check("arst_pre_gnt", 64'(gnt), 64'(4'b0001));
    step();
    #2 rst_i = 1'b1;
    s_req[0].cyc = 1'b0;
    #1;
    check("arst_gnt", 64'(gnt), 64'(0));
    check("arst_m_adr", 64'(m_req.adr), 64'(32'hFFFF_FFFF));
    check("arst_s_ack", 64'(s_resp[0].ack), 64'(0));
    #2 rst_i = 1'b0;
    repeat (12) step();
    check("arst_idle_gnt", 64'(gnt), 64'(0));

    check("resp_queue_empty", 64'(resp_q.size()), 64'(0));
    check("grant_queue_empty", 64'(gnt_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_io_arbiter256.md
WB_IO_ARBITER256 -- requirements
Module: wb_io_arbiter256

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the 256-bit I/O bridge port.
REQ-002 SHALL have parameter TIMEOUT, default 255, number of BUSY cycles without a response before a forced error.
REQ-003 SHALL have parameter IRQ_DEST, default 0, the requester that receives unsolicited IRQ responses.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port clk_i, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port s_req, input, wb_cmd_request256_t[NREQ], requester commands.
REQ-007 SHALL have port s_resp, output, wb_cmd_response256_t[NREQ], per-requester responses.
REQ-008 SHALL have port m_req, output, wb_cmd_request256_t, command to the bridge slave port.
REQ-009 SHALL have port m_resp, input, wb_cmd_response256_t, bridge response.
REQ-010 SHALL have port gnt, output, NREQ, one-hot current owner; all zero when idle.

Function
REQ-011 SHALL implement the states IDLE, BUSY, TMO and DRAIN.
REQ-012 In IDLE with any s_req[i].cyc=1, SHALL select the first requester at or after rr_ptr (modulo NREQ), register it into gnt and go to BUSY; grant latency is 1 cycle.
REQ-013 After each grant, SHALL set rr_ptr to the granted index +1, wrapping from NREQ-1 to 0.
REQ-014 In BUSY, m_req SHALL equal s_req[owner] combinationally.
REQ-015 In every state other than BUSY, m_req SHALL be all zero except adr=32'hFFFFFFFF.
REQ-016 In BUSY, s_resp[owner] SHALL equal m_resp combinationally, and all other s_resp SHALL be zero.
REQ-017 BUSY SHALL hold the grant across multiple ack cycles (bursts) for as long as s_req[owner].cyc=1.
REQ-018 When s_req[owner].cyc=0 in BUSY, the block SHALL go to IDLE next cycle and clear gnt; a new grant SHALL NOT occur in that same cycle.
REQ-019 The timeout counter SHALL be 8 bits wide minimum, sized to ceil(log2(TIMEOUT+1)), and SHALL clear on grant and on every m_resp.ack.
REQ-020 The timeout counter SHALL increment each BUSY cycle without m_resp.ack and SHALL saturate.
REQ-021 When the counter reaches TIMEOUT, the block SHALL go to TMO.
REQ-022 TMO SHALL last exactly one cycle, driving s_resp[owner].ack=1, err=wishbone_pkg::ERR, tid=s_req[owner].tid, dat=0, with m_req.cyc=0; it then SHALL go to DRAIN.
REQ-023 DRAIN SHALL hold gnt, drive s_resp[owner]=0 and m_req idle, and go to IDLE when s_req[owner].cyc=0.
REQ-024 A response with m_resp.ack=1 and err=wishbone_pkg::IRQ arriving in IDLE SHALL be forwarded to s_resp[IRQ_DEST] for that cycle only.
REQ-025 An IRQ response arriving in BUSY SHALL be forwarded to the owner unchanged, per REQ-016.
REQ-026 When both a grant request and an IRQ response occur in IDLE in the same cycle, both SHALL be honoured; the grant takes effect next cycle.
REQ-027 Requests from non-owners SHALL be ignored and never dropped; they stay pending until granted.
REQ-028 With NREQ=1, the block SHALL degenerate to pass-through plus one grant cycle and the timeout.

Reset
REQ-029 On rst_i=1, the block SHALL immediately enter IDLE and set gnt=0, rr_ptr=0, counter=0, all s_resp=0, and m_req per REQ-015.
REQ-030 Reset asserted mid-BUSY SHALL abort the transaction without any error response.

Verification
REQ-031 Single request: s_req[2].cyc=1, read, m_resp.ack on the 3rd BUSY cycle with dat=0xA5 replicated -> gnt=4'b0100 one cycle after cyc; s_resp[2].ack=1 with matching dat; IDLE one cycle after cyc drops.
REQ-032 Fairness: all 4 requesters hold cyc continuously, each transaction 1 ack then cyc drop/reassert -> grant order 0,1,2,3,0; no requester is granted twice before all others.
REQ-033 Timeout: TIMEOUT=8, owner 1 gets no ack -> s_resp[1].ack=1, err=ERR exactly on the cycle after 8 BUSY cycles; m_req.cyc=0 thereafter; IDLE after s_req[1].cyc drops.
REQ-034 Burst: owner 0 receives 4 acks on consecutive cycles while holding cyc -> gnt unchanged throughout; counter never reaches TIMEOUT.
REQ-035 IRQ in IDLE: m_resp.ack=1, err=IRQ, no cyc active -> s_resp[IRQ_DEST].ack=1 for 1 cycle; all other s_resp=0.
REQ-036 Async reset mid-BUSY: rst_i pulses between clock edges -> gnt=0 and m_req.adr=32'hFFFFFFFF before the next edge; no err response is issued.
